temp_monitor_ctrl: RTL
======================

# temp_monitor_ctrl

Periodic temperature-monitor controller. It requests samples from the 5-bit temperature sensor interface over a req/ack handshake, classifies each sample into baja/normal/alta/peligrosa, debounces class changes, and drives the committed class, fan and alarm outputs. It sits between the sensor front end and the display/actuator logic. It replaces free-running combinational decoding with a sequenced, filtered classification.

## Interface
Parameters:
- SAMPLE_PERIOD, 1000: idle cycles between the end of one evaluation and the next request (≥1).
- DEBOUNCE, 3: consecutive equal samples required to commit a non-peligrosa class change (1–15).
- ACK_TIMEOUT, 255: maximum cycles sample_req stays high without sample_ack (≥1).
- LOW_MAX, 6: highest temp_in classified baja.
- NORM_MAX, 9: highest temp_in classified normal.
- HIGH_MAX, 11: highest temp_in classified alta; anything above is peligrosa.

Ports:
- clk  in  1  system clock. Single clock domain.
- reset  in  1  synchronous, active-high reset.
- en  in  1  enables sampling. Low forces IDLE.
- sample_req  out  1  sample request to the sensor.
- sample_ack  in  1  sensor ack. temp_in is valid in the same cycle.
- temp_in  in  5  sensor temperature code.
- alarm_clr  in  1  clears the latched alarm (macro-dependent).
- clase  out  4  committed class, one-hot: 1000 baja, 0100 normal, 0010 alta, 0001 peligrosa. 0000 means none yet.
- class_valid  out  1  one-cycle pulse on every commit.
- fan_on  out  1  high while clase is alta or peligrosa.
- alarm  out  1  peligrosa or sensor error indication.
- sensor_err  out  1  set by an ack timeout; cleared by the next successful ack.

## Operation
- States: IDLE, WAIT, REQ, EVAL.
- IDLE:
  - Outputs hold.
  - Moves to REQ when en=1 on the first entry after reset.
  - Afterwards, moves to WAIT when en=1.
- WAIT:
  - Period counter counts 0..SAMPLE_PERIOD-1.
  - At terminal count, moves to REQ.
- REQ:
  - sample_req=1 and the timeout counter runs.
  - On sample_ack: capture temp_in, clear sensor_err, go to EVAL.
  - On timeout (ACK_TIMEOUT cycles with no ack): set sensor_err, go to WAIT, no evaluation.
- EVAL (one cycle): classify the captured sample (temp ≤ LOW_MAX baja; ≤ NORM_MAX normal; ≤ HIGH_MAX alta; else peligrosa). Then apply the debounce rules, then go to WAIT:
  - No committed class yet: commit immediately.
  - Sample class is peligrosa: commit immediately (safety bypass).
  - Sample class equals committed: candidate count clears to 0.
  - Sample class equals candidate: count increments. At count==DEBOUNCE, commit and clear the count.
  - Otherwise: candidate takes the sample class and count becomes 1. If DEBOUNCE==1, commit.
- Commit: update clase and pulse class_valid, even if clase is unchanged by the immediate paths.
- Comparisons are unsigned 5-bit. Counters saturate and never wrap.
- en low in any state: IDLE next cycle. sample_req drops, counters clear, candidate and clase are kept.
- reset mid-operation: all state returns to reset values next cycle.

## Timing
- Reset values:
  - clase=0000, class_valid=0, fan_on=0, alarm=0, sensor_err=0, sample_req=0.
  - State IDLE; candidate and counters cleared.
- Handshake:
  - sample_req rises the cycle after entering REQ and stays high until sample_ack is sampled.
  - It is low the cycle after the ack.
  - An ack while sample_req=0 is ignored.
- Ack and timeout in the same cycle: ack wins.
- Latency:
  - ack at cycle T: EVAL at T+1.
  - clase, class_valid and fan_on are registered and updated at T+2.
  - Next sample_req at T+2+SAMPLE_PERIOD.
- sensor_err is registered on the cycle after the timeout.
- alarm is registered from the next clase/sensor_err.

## Configuration
- TEMP_ALARM_LATCH_EN:
  - Defined: alarm is sticky. It sets on peligrosa or sensor_err and clears only on alarm_clr=1 while clase≠peligrosa and sensor_err=0.
  - If alarm_clr and a set condition occur in the same cycle, set wins.
  - Undefined: alarm = (clase==0001) | sensor_err, registered, and alarm_clr is ignored.

## Structure
- Shared package `temp_pkg`:
  - Class one-hot localparams: CLS_BAJA, CLS_NORMAL, CLS_ALTA, CLS_PELIGROSA, CLS_NONE.
  - FSM state encodings.
  - Default thresholds 6/9/11.
- Sub-module `temp_classifier`: combinational 5-bit to one-hot class mapping with threshold parameters, instantiated once in EVAL.

## Test plan
All scenarios use SAMPLE_PERIOD=4, DEBOUNCE=3, ACK_TIMEOUT=8.
- Reset and first sample:
  - Stimulus: reset, en=1, ack with temp 5.
  - Response: clase=1000 two cycles after the ack, class_valid pulses once, fan_on=0.
- Debounce:
  - Stimulus: committed normal (8), then samples 10, 10, 10.
  - Response: clase stays 0100 after the 1st and 2nd samples and becomes 0010 after the 3rd; fan_on=1.
- Interrupted candidate:
  - Stimulus: committed normal, samples 10, 5, 10, 10.
  - Response: no commit.
- Safety bypass:
  - Stimulus: committed normal, single sample 20.
  - Response: clase=0001 and alarm=1 two cycles after the ack.
- Timeout:
  - Stimulus: no ack.
  - Response: sample_req high for exactly 8 cycles, sensor_err=1, alarm=1, next req after 4 WAIT cycles.
  - Follow-up: a good ack clears sensor_err.
- en drop and latch:
  - Stimulus: en=0 while in REQ.
  - Response: sample_req=0 next cycle, clase held.
  - With TEMP_ALARM_LATCH_EN: after peligrosa returns to normal, alarm stays 1 until alarm_clr, then reads 0.

Source files
------------

// File: rtl/temp_monitor_ctrl_pkg.sv
// Shared definitions for the temperature monitor: one-hot class codes,
// controller state encoding and default classification thresholds.
package temp_pkg;

  localparam logic [3:0] CLS_NONE      = 4'b0000;
  localparam logic [3:0] CLS_BAJA      = 4'b1000;
  localparam logic [3:0] CLS_NORMAL    = 4'b0100;
  localparam logic [3:0] CLS_ALTA      = 4'b0010;
  localparam logic [3:0] CLS_PELIGROSA = 4'b0001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_REQ  = 2'd2,
    ST_EVAL = 2'd3
  } state_e;

  localparam int unsigned DEF_LOW_MAX  = 6;
  localparam int unsigned DEF_NORM_MAX = 9;
  localparam int unsigned DEF_HIGH_MAX = 11;

  function automatic logic fan_needed(input logic [3:0] cls);
    return (cls == CLS_ALTA) || (cls == CLS_PELIGROSA);
  endfunction

endpackage

// File: rtl/temp_monitor_ctrl_if.sv
// Sensor handshake bundle: the controller (master) requests, the sensor
// (slave) acknowledges with temp_in valid in the same cycle.
interface temp_monitor_ctrl_if;
  logic       sample_req;
  logic       sample_ack;
  logic [4:0] temp_in;

  modport master (output sample_req, input sample_ack, input temp_in);
  modport slave  (input sample_req, output sample_ack, output temp_in);
endinterface

// File: rtl/temp_monitor_ctrl_classifier.sv
// Combinational mapping of a 5-bit temperature code to a one-hot class,
// using unsigned inclusive upper thresholds.
module temp_classifier
  import temp_pkg::*;
#(
  parameter int unsigned LOW_MAX  = DEF_LOW_MAX,
  parameter int unsigned NORM_MAX = DEF_NORM_MAX,
  parameter int unsigned HIGH_MAX = DEF_HIGH_MAX
) (
  input  logic [4:0] temp_i,
  output logic [3:0] cls_o
);

  localparam logic [4:0] LOW_T  = 5'(LOW_MAX);
  localparam logic [4:0] NORM_T = 5'(NORM_MAX);
  localparam logic [4:0] HIGH_T = 5'(HIGH_MAX);

  always_comb begin
    cls_o = CLS_PELIGROSA;
    if (temp_i <= LOW_T) begin
      cls_o = CLS_BAJA;
    end else if (temp_i <= NORM_T) begin
      cls_o = CLS_NORMAL;
    end else if (temp_i <= HIGH_T) begin
      cls_o = CLS_ALTA;
    end
  end

endmodule

// File: rtl/temp_monitor_ctrl.sv
// Periodic temperature monitor: request/ack sampling, classification with
// debounced commits, fan and alarm outputs. Build macro TEMP_ALARM_LATCH_EN
// makes the alarm sticky until cleared by alarm_clr.
module temp_monitor_ctrl
  import temp_pkg::*;
#(
  parameter int unsigned SAMPLE_PERIOD = 1000,
  parameter int unsigned DEBOUNCE      = 3,
  parameter int unsigned ACK_TIMEOUT   = 255,
  parameter int unsigned LOW_MAX       = DEF_LOW_MAX,
  parameter int unsigned NORM_MAX      = DEF_NORM_MAX,
  parameter int unsigned HIGH_MAX      = DEF_HIGH_MAX
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       alarm_clr,
  temp_monitor_ctrl_if.master        sif,
  output logic [3:0]                 clase,
  output logic                       class_valid,
  output logic                       fan_on,
  output logic                       alarm,
  output logic                       sensor_err
);

  localparam int unsigned     PW       = $clog2(SAMPLE_PERIOD + 1);
  localparam int unsigned     TW       = $clog2(ACK_TIMEOUT + 1);
  localparam logic [PW-1:0]   PER_LAST = PW'(SAMPLE_PERIOD - 1);
  localparam logic [TW-1:0]   TO_LAST  = TW'(ACK_TIMEOUT - 1);
  localparam logic [3:0]      DEB_T    = 4'(DEBOUNCE);

  state_e        state_q, state_d;
  logic          first_q, first_d;
  logic [PW-1:0] period_cnt_q, period_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [4:0]    sample_q, sample_d;
  logic [3:0]    clase_q, clase_d;
  logic [3:0]    cand_q, cand_d;
  logic [3:0]    deb_cnt_q, deb_cnt_d;
  logic          sensor_err_q, sensor_err_d;
  logic          class_valid_q, fan_on_q;
  logic          alarm_q, alarm_d, alarm_set;
  logic          ack_take, timeout_hit, per_done, eval_go, commit;
  logic [3:0]    samp_cls;

  temp_classifier #(
    .LOW_MAX (LOW_MAX),
    .NORM_MAX(NORM_MAX),
    .HIGH_MAX(HIGH_MAX)
  ) u_classifier (
    .temp_i(sample_q),
    .cls_o (samp_cls)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    first_d = first_q;
    if (!en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = first_q ? ST_REQ : ST_WAIT;
          first_d = 1'b0;
        end
        ST_WAIT: if (per_done) state_d = ST_REQ;
        ST_REQ: begin
          if (ack_take)         state_d = ST_EVAL;
          else if (timeout_hit) state_d = ST_WAIT;
        end
        ST_EVAL: state_d = ST_WAIT;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs and qualified events; an ack outside REQ is ignored
  always_comb begin
    sif.sample_req = (state_q == ST_REQ);
    ack_take       = en && (state_q == ST_REQ) && sif.sample_ack;
    timeout_hit    = en && (state_q == ST_REQ) && !sif.sample_ack && (to_cnt_q == TO_LAST);
    per_done       = (state_q == ST_WAIT) && (period_cnt_q == PER_LAST);
    eval_go        = en && (state_q == ST_EVAL);
  end

  always_comb begin
    period_cnt_d = '0;
    to_cnt_d     = '0;
    if (en && (state_q == ST_WAIT) && !per_done) begin
      period_cnt_d = period_cnt_q + 1'b1;
    end
    if (en && (state_q == ST_REQ) && !sif.sample_ack && (to_cnt_q != TO_LAST)) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  always_comb begin
    sample_d     = ack_take ? sif.temp_in : sample_q;
    sensor_err_d = sensor_err_q;
    if (ack_take) begin
      sensor_err_d = 1'b0;
    end else if (timeout_hit) begin
      sensor_err_d = 1'b1;
    end

    clase_d   = clase_q;
    cand_d    = cand_q;
    deb_cnt_d = deb_cnt_q;
    commit    = 1'b0;
    if (eval_go) begin
      // First sample and peligrosa bypass the debounce filter
      if ((clase_q == CLS_NONE) || (samp_cls == CLS_PELIGROSA)) begin
        commit    = 1'b1;
        clase_d   = samp_cls;
        deb_cnt_d = '0;
      end else if (samp_cls == clase_q) begin
        deb_cnt_d = '0;
      end else if (samp_cls == cand_q) begin
        if (deb_cnt_q >= DEB_T - 4'd1) begin
          commit    = 1'b1;
          clase_d   = samp_cls;
          deb_cnt_d = '0;
        end else if (deb_cnt_q != 4'hF) begin
          deb_cnt_d = deb_cnt_q + 4'd1;
        end
      end else begin
        cand_d    = samp_cls;
        deb_cnt_d = 4'd1;
        if (DEB_T == 4'd1) begin
          commit    = 1'b1;
          clase_d   = samp_cls;
          deb_cnt_d = '0;
        end
      end
    end else if (!en) begin
      deb_cnt_d = '0;
    end
  end

  assign alarm_set = (clase_d == CLS_PELIGROSA) || sensor_err_d;

`ifdef TEMP_ALARM_LATCH_EN
  always_comb begin
    alarm_d = alarm_q;
    if (alarm_set) begin
      alarm_d = 1'b1;
    end else if (alarm_clr) begin
      alarm_d = 1'b0;
    end
  end
`else
  logic unused_alarm_clr;
  assign unused_alarm_clr = alarm_clr;
  always_comb alarm_d = alarm_set;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      period_cnt_q  <= '0;
      to_cnt_q      <= '0;
      sample_q      <= '0;
      clase_q       <= CLS_NONE;
      cand_q        <= CLS_NONE;
      deb_cnt_q     <= '0;
      sensor_err_q  <= 1'b0;
      class_valid_q <= 1'b0;
      fan_on_q      <= 1'b0;
      alarm_q       <= 1'b0;
    end else begin
      period_cnt_q  <= period_cnt_d;
      to_cnt_q      <= to_cnt_d;
      sample_q      <= sample_d;
      clase_q       <= clase_d;
      cand_q        <= cand_d;
      deb_cnt_q     <= deb_cnt_d;
      sensor_err_q  <= sensor_err_d;
      class_valid_q <= commit;
      fan_on_q      <= fan_needed(clase_d);
      alarm_q       <= alarm_d;
    end
  end

  assign clase       = clase_q;
  assign class_valid = class_valid_q;
  assign fan_on      = fan_on_q;
  assign alarm       = alarm_q;
  assign sensor_err  = sensor_err_q;

endmodule
